// File: rtl/snake_body_arbiter.sv
// Snake body queue: circular {x,y} buffer with a clear sequencer and a
// push > read arbiter. Define SNAKE_BODY_ARB_RR_EN for round-robin VGA/generator reads.
//
//   state | meaning
//   CLEAR | writing the sentinel to entry cc, one entry per cycle, no grants
//   RUN   | serving clear, push and read requests, one grant per cycle

module snake_body_arbiter #(
    parameter int MAX_SIZE = 20,
    parameter int IDX_W    = 5,
    parameter int CLR_X    = 47,
    parameter int CLR_Y    = 63
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Clr_Req,
    output logic             o_Clr_Busy,
    input  logic             i_Push_Req,
    input  logic [5:0]       i_Push_x,
    input  logic [5:0]       i_Push_y,
    output logic             o_Push_Gnt,
    input  logic             i_V_Req,
    input  logic [IDX_W-1:0] i_V_Idx,
    output logic             o_V_Gnt,
    output logic             o_V_Rvalid,
    input  logic             i_G_Req,
    input  logic [IDX_W-1:0] i_G_Idx,
    output logic             o_G_Gnt,
    output logic             o_G_Rvalid,
    output logic [5:0]       o_Rd_x,
    output logic [5:0]       o_Rd_y
);

    localparam int PTR_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam int SUM_W = ((PTR_W > IDX_W) ? PTR_W : IDX_W) + 1;
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(MAX_SIZE - 1);
    localparam logic [11:0]      SENTINEL = {6'(CLR_X), 6'(CLR_Y)};

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [PTR_W-1:0] r_cc;
    logic [PTR_W-1:0] r_hp;
    logic [PTR_W-1:0] w_hp_dec;
    logic [11:0]      r_mem [MAX_SIZE];
    logic [11:0]      r_rd;
    logic             r_v_rvalid;
    logic             r_g_rvalid;

    logic             w_push_gnt;
    logic             w_v_gnt;
    logic             w_g_gnt;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_addr;
    logic [11:0]      w_wr_data;
    logic [IDX_W-1:0] w_rd_idx;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_phys;
    logic [PTR_W-1:0] w_rd_addr;
    logic             w_rd_oob;

`ifdef SNAKE_BODY_ARB_RR_EN
    logic             r_last_g;
`endif

    assign w_hp_dec = (r_hp == '0) ? LAST : r_hp - PTR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_push_gnt  = 1'b0;
        w_v_gnt     = 1'b0;
        w_g_gnt     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_cc;
        w_wr_data   = SENTINEL;
        if (r_state == CLEAR) begin
            w_wr_en = 1'b1;
            if (r_cc == LAST) begin
                w_state_nxt = RUN;
            end
        end else begin
            if (i_Clr_Req) begin
                w_state_nxt = CLEAR;
            end else if (i_Push_Req) begin
                w_push_gnt = 1'b1;
                w_wr_en    = 1'b1;
                w_wr_addr  = w_hp_dec;
                w_wr_data  = {i_Push_x, i_Push_y};
            end else begin
`ifdef SNAKE_BODY_ARB_RR_EN
                // On contention the requester not served last wins.
                if (i_V_Req && i_G_Req) begin
                    w_v_gnt = r_last_g;
                    w_g_gnt = ~r_last_g;
                end else begin
                    w_v_gnt = i_V_Req;
                    w_g_gnt = i_G_Req;
                end
`else
                w_v_gnt = i_V_Req;
                w_g_gnt = i_G_Req & ~i_V_Req;
`endif
            end
        end
    end

    // Logical index is relative to the head; indices past the depth read the sentinel.
    assign w_rd_idx  = w_g_gnt ? i_G_Idx : i_V_Idx;
    assign w_sum     = SUM_W'(r_hp) + SUM_W'(w_rd_idx);
    assign w_phys    = (w_sum >= SUM_W'(MAX_SIZE)) ? (w_sum - SUM_W'(MAX_SIZE)) : w_sum;
    assign w_rd_addr = w_phys[PTR_W-1:0];
    assign w_rd_oob  = (SUM_W'(w_rd_idx) >= SUM_W'(MAX_SIZE));

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state <= CLEAR;
            r_cc    <= '0;
            r_hp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                if (r_cc == LAST) begin
                    r_cc <= '0;
                    r_hp <= '0;
                end else begin
                    r_cc <= r_cc + PTR_W'(1);
                end
            end else begin
                r_cc <= '0;
                if (w_push_gnt) begin
                    r_hp <= w_hp_dec;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_rd       <= '0;
            r_v_rvalid <= 1'b0;
            r_g_rvalid <= 1'b0;
        end else begin
            r_v_rvalid <= w_v_gnt;
            r_g_rvalid <= w_g_gnt;
            if (w_v_gnt || w_g_gnt) begin
                r_rd <= w_rd_oob ? SENTINEL : r_mem[w_rd_addr];
            end
        end
    end

`ifdef SNAKE_BODY_ARB_RR_EN
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_last_g <= 1'b0;
        end else if (w_v_gnt) begin
            r_last_g <= 1'b0;
        end else if (w_g_gnt) begin
            r_last_g <= 1'b1;
        end
    end
`endif

    assign o_Clr_Busy = (r_state == CLEAR);
    assign o_Push_Gnt = w_push_gnt;
    assign o_V_Gnt    = w_v_gnt;
    assign o_G_Gnt    = w_g_gnt;
    assign o_V_Rvalid = r_v_rvalid;
    assign o_G_Rvalid = r_g_rvalid;
    assign o_Rd_x     = r_rd[11:6];
    assign o_Rd_y     = r_rd[5:0];

endmodule

// File: tb/tb_snake_body_arbiter.sv
// Directed bench for snake_body_arbiter: clear timing, push/read ordering,
// wrap, arbitration priority and reset/clear interaction.

module tb_snake_body_arbiter;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b0;
    logic       i_Clr_Req = 1'b0;
    logic       o_Clr_Busy;
    logic       i_Push_Req = 1'b0;
    logic [5:0] i_Push_x = '0;
    logic [5:0] i_Push_y = '0;
    logic       o_Push_Gnt;
    logic       i_V_Req = 1'b0;
    logic [4:0] i_V_Idx = '0;
    logic       o_V_Gnt;
    logic       o_V_Rvalid;
    logic       i_G_Req = 1'b0;
    logic [4:0] i_G_Idx = '0;
    logic       o_G_Gnt;
    logic       o_G_Rvalid;
    logic [5:0] o_Rd_x;
    logic [5:0] o_Rd_y;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] SENT = {6'd47, 6'd63};

    snake_body_arbiter dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst),
        .i_Clr_Req(i_Clr_Req), .o_Clr_Busy(o_Clr_Busy),
        .i_Push_Req(i_Push_Req), .i_Push_x(i_Push_x), .i_Push_y(i_Push_y),
        .o_Push_Gnt(o_Push_Gnt),
        .i_V_Req(i_V_Req), .i_V_Idx(i_V_Idx), .o_V_Gnt(o_V_Gnt), .o_V_Rvalid(o_V_Rvalid),
        .i_G_Req(i_G_Req), .i_G_Idx(i_G_Idx), .o_G_Gnt(o_G_Gnt), .o_G_Rvalid(o_G_Rvalid),
        .o_Rd_x(o_Rd_x), .o_Rd_y(o_Rd_y)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Stimulus helpers: return data and whether the grant/Rvalid handshake completed.
    task automatic v_read(input logic [4:0] idx, output logic [11:0] data, output logic ok);
        int n = 0;
        i_V_Req = 1'b1;
        i_V_Idx = idx;
        #1;
        while (!o_V_Gnt && n < 10) begin
            tick();
            n++;
        end
        ok = 1'b0;
        data = '0;
        if (o_V_Gnt) begin
            tick();
            ok = o_V_Rvalid;
            data = {o_Rd_x, o_Rd_y};
        end
        i_V_Req = 1'b0;
    endtask

    task automatic g_read(input logic [4:0] idx, output logic [11:0] data, output logic ok);
        int n = 0;
        i_G_Req = 1'b1;
        i_G_Idx = idx;
        #1;
        while (!o_G_Gnt && n < 10) begin
            tick();
            n++;
        end
        ok = 1'b0;
        data = '0;
        if (o_G_Gnt) begin
            tick();
            ok = o_G_Rvalid;
            data = {o_Rd_x, o_Rd_y};
        end
        i_G_Req = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        i_Clr_Req = 1'b1; i_Push_Req = 1'b1; i_V_Req = 1'b1; i_G_Req = 1'b1;
        #2;
        checks++;
        if (o_Clr_Busy !== 1'b1 || o_V_Rvalid !== 1'b0 || o_G_Rvalid !== 1'b0 ||
            {o_Rd_x, o_Rd_y} !== 12'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b vr=%b gr=%b rd=%h need 1 0 0 000",
                     o_Clr_Busy, o_V_Rvalid, o_G_Rvalid, {o_Rd_x, o_Rd_y});
        end
        tick();
        i_Rst = 1'b1;
        #1;
        while (o_Clr_Busy && n < 100) begin
            checks++;
            if ({o_Push_Gnt, o_V_Gnt, o_G_Gnt} !== 3'b000) begin
                errors++;
                $display("FAIL clear_no_grant cycle %0d got %b need 000", n, {o_Push_Gnt, o_V_Gnt, o_G_Gnt});
            end
            tick();
            n++;
        end
        i_Clr_Req = 1'b0; i_Push_Req = 1'b0; i_V_Req = 1'b0; i_G_Req = 1'b0;
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL reset_clear_len got %0d cycles need 20", n);
        end
    endtask

    task automatic test_clear_contents();
        logic [11:0] d;
        logic ok;
        for (int i = 0; i < 20; i++) begin
            v_read(5'(i), d, ok);
            checks++;
            if (!ok || d !== SENT) begin
                errors++;
                $display("FAIL clear_entry idx %0d got ok=%b %h need %h", i, ok, d, SENT);
            end
        end
    endtask

    task automatic test_push3();
        logic [11:0] d;
        logic ok;
        logic [11:0] exp_v [4];
        logic [4:0]  idx_v [4];
        exp_v[0] = {6'd26, 6'd32}; idx_v[0] = 5'd0;
        exp_v[1] = {6'd25, 6'd32}; idx_v[1] = 5'd1;
        exp_v[2] = {6'd24, 6'd32}; idx_v[2] = 5'd2;
        exp_v[3] = SENT;           idx_v[3] = 5'd3;
        i_Push_Req = 1'b1;
        i_Push_y = 6'd32;
        for (int i = 0; i < 3; i++) begin
            i_Push_x = 6'(24 + i);
            #1;
            checks++;
            if (o_Push_Gnt !== 1'b1) begin
                errors++;
                $display("FAIL push3_gnt push %0d got %b need 1", i, o_Push_Gnt);
            end
            tick();
        end
        i_Push_Req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v_read(idx_v[i], d, ok);
            checks++;
            if (!ok || d !== exp_v[i]) begin
                errors++;
                $display("FAIL push3_read idx %0d got ok=%b %h need %h", idx_v[i], ok, d, exp_v[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] d;
        logic ok;
        i_Push_Req = 1'b1;
        i_Push_y = 6'd5;
        for (int i = 1; i <= 21; i++) begin
            i_Push_x = 6'(i);
            tick();
        end
        i_Push_Req = 1'b0;
        // hp was 17 after the three earlier pushes; 21 more decrements wrap it to 16.
        checks++;
        if (dut.r_hp !== 5'd16) begin
            errors++;
            $display("FAIL wrap_hp got %0d need 16", dut.r_hp);
        end
        v_read(5'd0, d, ok);
        checks++;
        if (!ok || d !== {6'd21, 6'd5}) begin
            errors++;
            $display("FAIL wrap_idx0 got ok=%b %h need %h", ok, d, {6'd21, 6'd5});
        end
        v_read(5'd19, d, ok);
        checks++;
        if (!ok || d !== {6'd2, 6'd5}) begin
            errors++;
            $display("FAIL wrap_idx19 got ok=%b %h need %h", ok, d, {6'd2, 6'd5});
        end
        v_read(5'd20, d, ok);
        checks++;
        if (!ok || d !== SENT) begin
            errors++;
            $display("FAIL oob_idx20 got ok=%b %h need %h", ok, d, SENT);
        end
        g_read(5'd31, d, ok);
        checks++;
        if (!ok || d !== SENT) begin
            errors++;
            $display("FAIL oob_idx31 got ok=%b %h need %h", ok, d, SENT);
        end
        g_read(5'd1, d, ok);
        checks++;
        if (!ok || d !== {6'd20, 6'd5}) begin
            errors++;
            $display("FAIL g_idx1 got ok=%b %h need %h", ok, d, {6'd20, 6'd5});
        end
    endtask

    task automatic test_priority();
        i_Push_Req = 1'b1; i_Push_x = 6'd9; i_Push_y = 6'd9;
        i_V_Req = 1'b1; i_V_Idx = 5'd0;
        i_G_Req = 1'b1; i_G_Idx = 5'd1;
        #1;
        checks++;
        if ({o_Push_Gnt, o_V_Gnt, o_G_Gnt} !== 3'b100) begin
            errors++;
            $display("FAIL prio_push got %b need 100", {o_Push_Gnt, o_V_Gnt, o_G_Gnt});
        end
        tick();
        i_Push_Req = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
`ifdef SNAKE_BODY_ARB_RR_EN
            // Last read before this test was a generator read, so VGA goes first.
            checks++;
            if ({o_V_Gnt, o_G_Gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_alt cycle %0d got %b need %b", c, {o_V_Gnt, o_G_Gnt},
                         (c % 2 == 0) ? 2'b10 : 2'b01);
            end
`else
            checks++;
            if ({o_V_Gnt, o_G_Gnt} !== 2'b10) begin
                errors++;
                $display("FAIL fixed_prio cycle %0d got %b need 10", c, {o_V_Gnt, o_G_Gnt});
            end
`endif
            tick();
            checks++;
            if (o_V_Rvalid !== 1'b1 && o_G_Rvalid !== 1'b1) begin
                errors++;
                $display("FAIL prio_rvalid cycle %0d got v=%b g=%b need one high", c, o_V_Rvalid, o_G_Rvalid);
            end
`ifndef SNAKE_BODY_ARB_RR_EN
            checks++;
            if (o_G_Rvalid !== 1'b0 || {o_Rd_x, o_Rd_y} !== {6'd9, 6'd9}) begin
                errors++;
                $display("FAIL fixed_data cycle %0d got g=%b %h need 0 %h", c, o_G_Rvalid,
                         {o_Rd_x, o_Rd_y}, {6'd9, 6'd9});
            end
`endif
        end
        i_V_Req = 1'b0; i_G_Req = 1'b0;
        tick();
        checks++;
        if (o_V_Rvalid !== 1'b0 || o_G_Rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_one_shot got v=%b g=%b need 0 0", o_V_Rvalid, o_G_Rvalid);
        end
    endtask

    task automatic test_clr_during_read();
        int n = 0;
        i_V_Req = 1'b1; i_V_Idx = 5'd0;
        #1;
        checks++;
        if (o_V_Gnt !== 1'b1) begin
            errors++;
            $display("FAIL clr_read_gnt got %b need 1", o_V_Gnt);
        end
        tick();
        i_Clr_Req = 1'b1; i_Push_Req = 1'b1; i_G_Req = 1'b1;
        #1;
        checks++;
        if (o_V_Rvalid !== 1'b1 || {o_Rd_x, o_Rd_y} !== {6'd9, 6'd9}) begin
            errors++;
            $display("FAIL clr_read_rvalid got v=%b %h need 1 %h", o_V_Rvalid, {o_Rd_x, o_Rd_y}, {6'd9, 6'd9});
        end
        checks++;
        if ({o_Push_Gnt, o_V_Gnt, o_G_Gnt} !== 3'b000) begin
            errors++;
            $display("FAIL clr_over_push got %b need 000", {o_Push_Gnt, o_V_Gnt, o_G_Gnt});
        end
        tick();
        while (o_Clr_Busy && n < 100) begin
            checks++;
            if ({o_Push_Gnt, o_V_Gnt, o_G_Gnt} !== 3'b000) begin
                errors++;
                $display("FAIL clr_busy_grant cycle %0d got %b need 000", n, {o_Push_Gnt, o_V_Gnt, o_G_Gnt});
            end
            tick();
            n++;
        end
        i_Clr_Req = 1'b0; i_Push_Req = 1'b0; i_V_Req = 1'b0; i_G_Req = 1'b0;
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL clr_len got %0d cycles need 20", n);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [11:0] d;
        logic ok;
        int n = 0;
        i_Clr_Req = 1'b1;
        tick();
        i_Clr_Req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        i_Rst = 1'b0;
        #1;
        i_Rst = 1'b1;
        #1;
        while (o_Clr_Busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL rst_mid_clear_len got %0d cycles need 20", n);
        end
        // Reset between a grant and its data edge must swallow the Rvalid.
        i_V_Req = 1'b1; i_V_Idx = 5'd0;
        #1;
        i_Rst = 1'b0;
        i_V_Req = 1'b0;
        tick();
        checks++;
        if (o_V_Rvalid !== 1'b0 || o_Clr_Busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_read got v=%b busy=%b need 0 1", o_V_Rvalid, o_Clr_Busy);
        end
        i_Rst = 1'b1;
        n = 0;
        while (o_Clr_Busy && n < 100) begin
            checks++;
            if (o_V_Rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rst_rvalid_leak cycle %0d got 1 need 0", n);
            end
            tick();
            n++;
        end
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL rst_mid_read_len got %0d cycles need 20", n);
        end
        v_read(5'd0, d, ok);
        checks++;
        if (!ok || d !== SENT) begin
            errors++;
            $display("FAIL post_reset_idx0 got ok=%b %h need %h", ok, d, SENT);
        end
    endtask

    initial begin
        test_reset();
        test_clear_contents();
        test_push3();
        test_wrap();
        test_priority();
        test_clr_during_read();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
